fpu_issue_ctrl: RTL and testbench

- Issue scoreboard and sequencer sitting between the SH-4 FP decode stage and the fpu datapath.
- Tracks pending writebacks from the pipelined FMA unit per FP register tag ({bank, rn}, 5 bits).
- Stalls decode on RAW/WAW hazards or a full pipe, and counts in-flight ops.
- Drains the pipe before FPSCR writes, so rounding mode and bank select never change under in-flight ops.

---
 rtl/fpu_pkg.sv | 20 ++
 rtl/fpu_issue_ctrl_if.sv | 33 +++
 rtl/fpu_scoreboard.sv | 51 +++++
 rtl/fpu_issue_ctrl.sv | 101 ++++++++++
 tb/tb_fpu_issue_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared constants, drain FSM encoding and tag helper for the SH-4 FP issue controller.
package fpu_pkg;

  localparam int FPU_TAG_W        = 5;
  localparam int FPU_NREGS        = 1 << FPU_TAG_W;
  localparam int FPU_MAX_INFLIGHT = 4;
  localparam int FPU_CNT_W        = 3;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    ACK   = 2'd2
  } drain_state_e;

  // Register tag as seen by the scoreboard: bank select on top of the register number.
  function automatic logic [FPU_TAG_W-1:0] fr_tag(input logic fr, input logic [3:0] rn);
    return {fr, rn};
  endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// Decode-to-issue handshake plus the FMA-pipe writeback return path.
interface fpu_issue_ctrl_if
  import fpu_pkg::*;
#(
  parameter int TAG_W = FPU_TAG_W
);
  logic             dec_valid;
  logic             dec_ready;
  logic             dec_src0_en;
  logic [TAG_W-1:0] dec_src0_tag;
  logic             dec_src1_en;
  logic [TAG_W-1:0] dec_src1_tag;
  logic             dec_src2_en;
  logic [TAG_W-1:0] dec_src2_tag;
  logic             dec_dst_en;
  logic [TAG_W-1:0] dec_dst_tag;
  logic             issue_valid;
  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;

  // master: decode stage and fpu datapath; slave: the issue controller
  modport master (
    output dec_valid, dec_src0_en, dec_src0_tag, dec_src1_en, dec_src1_tag,
           dec_src2_en, dec_src2_tag, dec_dst_en, dec_dst_tag, wb_valid, wb_tag,
    input  dec_ready, issue_valid
  );

  modport slave (
    input  dec_valid, dec_src0_en, dec_src0_tag, dec_src1_en, dec_src1_tag,
           dec_src2_en, dec_src2_tag, dec_dst_en, dec_dst_tag, wb_valid, wb_tag,
    output dec_ready, issue_valid
  );
endinterface

// File: rtl/fpu_scoreboard.sv
// Pending-writeback bit per FP register tag, with three source read ports and
// sticky detection of writebacks that match no outstanding op.
module fpu_scoreboard
  import fpu_pkg::*;
#(
  parameter int NREGS = FPU_NREGS,
  parameter int TAG_W = FPU_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [TAG_W-1:0] set_tag,
  input  logic             clr_en,
  input  logic [TAG_W-1:0] clr_tag,
  input  logic             cnt_zero,
  input  logic [TAG_W-1:0] rd0_tag,
  input  logic [TAG_W-1:0] rd1_tag,
  input  logic [TAG_W-1:0] rd2_tag,
  output logic             rd0_busy,
  output logic             rd1_busy,
  output logic             rd2_busy,
  output logic [NREGS-1:0] pending,
  output logic             err_wb
);

  logic [NREGS-1:0] pending_nxt;
  logic             err_hit;

  // Clear first so a set to the same tag wins; WAW blocking keeps that from happening normally.
  always_comb begin
    pending_nxt = pending;
    if (clr_en) pending_nxt[clr_tag] = 1'b0;
    if (set_en) pending_nxt[set_tag] = 1'b1;
  end

  assign err_hit  = clr_en & (~pending[clr_tag] | cnt_zero);
  assign rd0_busy = pending[rd0_tag];
  assign rd1_busy = pending[rd1_tag];
  assign rd2_busy = pending[rd2_tag];

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      err_wb  <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (err_hit) err_wb <= 1'b1;
    end
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue scoreboard and sequencer between SH-4 FP decode and the fpu datapath:
// RAW/WAW/full stalls, in-flight counting, and pipe drain ahead of FPSCR writes.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int NREGS        = FPU_NREGS,
  parameter int TAG_W        = FPU_TAG_W,
  parameter int MAX_INFLIGHT = FPU_MAX_INFLIGHT,
  parameter int CNT_W        = FPU_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  fpu_issue_ctrl_if.slave  bus,
  input  logic             fpscr_wr_req,
  output logic             fpscr_wr_ack,
  output logic             idle,
  output logic [CNT_W-1:0] inflight,
  output logic             err_wb
);

  drain_state_e     state, state_nxt;
  logic             ack_p1;
  logic [CNT_W-1:0] cnt;
  logic [NREGS-1:0] pending;
  logic             src0_busy, src1_busy, src2_busy;
  logic             haz, full, drain;
  logic             accept, issue_dst, wb_dec;

  fpu_scoreboard #(
    .NREGS (NREGS),
    .TAG_W (TAG_W)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (issue_dst),
    .set_tag  (bus.dec_dst_tag),
    .clr_en   (bus.wb_valid),
    .clr_tag  (bus.wb_tag),
    .cnt_zero (cnt == '0),
    .rd0_tag  (bus.dec_src0_tag),
    .rd1_tag  (bus.dec_src1_tag),
    .rd2_tag  (bus.dec_src2_tag),
    .rd0_busy (src0_busy),
    .rd1_busy (src1_busy),
    .rd2_busy (src2_busy),
    .pending  (pending),
    .err_wb   (err_wb)
  );

  // Hazards look only at registered pending bits; a writeback frees its tag one edge later.
  assign haz = (bus.dec_src0_en & src0_busy) |
               (bus.dec_src1_en & src1_busy) |
               (bus.dec_src2_en & src2_busy) |
               (bus.dec_dst_en  & pending[bus.dec_dst_tag]);

  assign full      = bus.dec_dst_en & (cnt == CNT_W'(MAX_INFLIGHT));
  assign drain     = (state != RUN);
  assign accept    = bus.dec_valid & ~haz & ~full & ~drain;
  assign issue_dst = accept & bus.dec_dst_en;
  assign wb_dec    = bus.wb_valid & (cnt != '0);

  assign bus.dec_ready   = accept;
  assign bus.issue_valid = accept;
  assign inflight        = cnt;
  assign idle            = (cnt == '0);
  assign fpscr_wr_ack    = (state == ACK);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      case ({issue_dst, wb_dec})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      ack_p1 <= 1'b0;
    end else begin
      state  <= state_nxt;
      ack_p1 <= (state == ACK);
    end
  end

  // The request is held until ack, so the cycle right after ACK must not re-trigger on it.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (fpscr_wr_req && !ack_p1) state_nxt = DRAIN;
      DRAIN:   if (cnt == '0) state_nxt = ACK;
      ACK:     state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: hazards, full pipe, dst-less ops, FPSCR drain, errors, reset.
module tb_fpu_issue_ctrl;
  import fpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       fpscr_wr_req;
  logic       fpscr_wr_ack;
  logic       idle;
  logic [2:0] inflight;
  logic       err_wb;
  int         checks = 0;
  int         errors = 0;

  fpu_issue_ctrl_if bus ();

  fpu_issue_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .fpscr_wr_req (fpscr_wr_req),
    .fpscr_wr_ack (fpscr_wr_ack),
    .idle         (idle),
    .inflight     (inflight),
    .err_wb       (err_wb)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic v, input logic s0e, input logic [4:0] s0,
                        input logic s1e, input logic [4:0] s1,
                        input logic s2e, input logic [4:0] s2,
                        input logic de, input logic [4:0] d);
    bus.dec_valid    = v;
    bus.dec_src0_en  = s0e; bus.dec_src0_tag = s0;
    bus.dec_src1_en  = s1e; bus.dec_src1_tag = s1;
    bus.dec_src2_en  = s2e; bus.dec_src2_tag = s2;
    bus.dec_dst_en   = de;  bus.dec_dst_tag  = d;
  endtask

  task automatic set_wb(input logic v, input logic [4:0] t);
    bus.wb_valid = v;
    bus.wb_tag   = t;
  endtask

  task automatic clear_in();
    set_op(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0);
    fpscr_wr_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_in();
    repeat (2) cycle();
    rst = 1'b0;
    #1;
    checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL reset_inflight got %0d want 0", inflight); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %0b want 1", idle); end
    checks++; if (bus.dec_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b want 0", bus.dec_ready); end
    checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue got %0b want 0", bus.issue_valid); end
    checks++; if (fpscr_wr_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %0b want 0", fpscr_wr_ack); end
    checks++; if (err_wb !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", err_wb); end
    checks++; if (dut.u_sb.pending !== 32'h0) begin errors++; $display("FAIL reset_pending got %h want 0", dut.u_sb.pending); end
  endtask

  task automatic test_raw();
    set_op(1, 0, 0, 0, 0, 0, 0, 1, 5'h03);
    #1;
    checks++; if (bus.dec_ready !== 1'b1) begin errors++; $display("FAIL raw_fmul_ready got %0b want 1", bus.dec_ready); end
    cycle();
    checks++; if (dut.u_sb.pending[3] !== 1'b1) begin errors++; $display("FAIL raw_pend3_set got %0b want 1", dut.u_sb.pending[3]); end
    set_op(1, 0, 0, 1, 5'h03, 0, 0, 1, 5'h08);
    #1;
    checks++; if (bus.dec_ready !== 1'b0) begin errors++; $display("FAIL raw_stall0 got %0b want 0", bus.dec_ready); end
    cycle();
    checks++; if (bus.dec_ready !== 1'b0) begin errors++; $display("FAIL raw_stall1 got %0b want 0", bus.dec_ready); end
    set_wb(1, 5'h03);
    #1;
    checks++; if (bus.dec_ready !== 1'b0) begin errors++; $display("FAIL raw_stall_wb got %0b want 0", bus.dec_ready); end
    cycle();
    set_wb(0, 0);
    #1;
    checks++; if (bus.issue_valid !== 1'b1) begin errors++; $display("FAIL raw_issue_after_wb got %0b want 1", bus.issue_valid); end
    checks++; if (dut.u_sb.pending[3] !== 1'b0) begin errors++; $display("FAIL raw_pend3_clr got %0b want 0", dut.u_sb.pending[3]); end
    cycle();
    checks++; if (inflight !== 3'd1) begin errors++; $display("FAIL raw_inflight got %0d want 1", inflight); end
    set_op(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_wb(1, 5'h08);
    cycle();
    set_wb(0, 0);
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL raw_idle_end got %0b want 1", idle); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      set_op(1, 0, 0, 0, 0, 0, 0, 1, 5'(i));
      #1;
      checks++; if (bus.dec_ready !== 1'b1) begin errors++; $display("FAIL full_b2b_ready%0d got %0b want 1", i, bus.dec_ready); end
      cycle();
    end
    set_op(1, 0, 0, 0, 0, 0, 0, 1, 5'h04);
    #1;
    checks++; if (bus.dec_ready !== 1'b0) begin errors++; $display("FAIL full_stall got %0b want 0", bus.dec_ready); end
    checks++; if (inflight !== 3'd4) begin errors++; $display("FAIL full_inflight got %0d want 4", inflight); end
    set_wb(1, 5'h00);
    #1;
    checks++; if (bus.dec_ready !== 1'b0) begin errors++; $display("FAIL full_stall_wb got %0b want 0", bus.dec_ready); end
    cycle();
    set_wb(0, 0);
    #1;
    checks++; if (bus.dec_ready !== 1'b1) begin errors++; $display("FAIL full_fifth_ready got %0b want 1", bus.dec_ready); end
    cycle();
    checks++; if (inflight !== 3'd4) begin errors++; $display("FAIL full_inflight_refill got %0d want 4", inflight); end
    checks++; if (dut.u_sb.pending[4:0] !== 5'b11110) begin errors++; $display("FAIL full_pending got %b want 11110", dut.u_sb.pending[4:0]); end
    set_op(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_wb(1, 5'h01);
    cycle();
    set_op(1, 0, 0, 0, 0, 0, 0, 1, 5'h00);
    set_wb(1, 5'h02);
    #1;
    checks++; if (bus.dec_ready !== 1'b1) begin errors++; $display("FAIL simul_ready got %0b want 1", bus.dec_ready); end
    cycle();
    checks++; if (inflight !== 3'd3) begin errors++; $display("FAIL simul_inflight got %0d want 3", inflight); end
    checks++; if (dut.u_sb.pending[4:0] !== 5'b11001) begin errors++; $display("FAIL simul_pending got %b want 11001", dut.u_sb.pending[4:0]); end
    set_op(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_wb(1, 5'h03); cycle();
    set_wb(1, 5'h04); cycle();
    set_wb(1, 5'h00); cycle();
    set_wb(0, 0);
    checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL full_drained got %0d want 0", inflight); end
    checks++; if (err_wb !== 1'b0) begin errors++; $display("FAIL full_no_err got %0b want 0", err_wb); end
  endtask

  task automatic test_no_dst();
    set_op(1, 0, 0, 0, 0, 0, 0, 1, 5'h02);
    cycle();
    set_op(1, 1, 5'h06, 1, 5'h07, 0, 0, 0, 0);
    #1;
    checks++; if (bus.issue_valid !== 1'b1) begin errors++; $display("FAIL fcmp_issue got %0b want 1", bus.issue_valid); end
    cycle();
    checks++; if (inflight !== 3'd1) begin errors++; $display("FAIL fcmp_inflight got %0d want 1", inflight); end
    set_op(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_wb(1, 5'h02);
    cycle();
    set_wb(0, 0);
  endtask

  task automatic test_drain();
    set_op(1, 0, 0, 0, 0, 0, 0, 1, 5'h0a); cycle();
    set_op(1, 0, 0, 0, 0, 0, 0, 1, 5'h0b); cycle();
    set_op(0, 0, 0, 0, 0, 0, 0, 0, 0);
    fpscr_wr_req = 1'b1;
    cycle();
    set_op(1, 0, 0, 0, 0, 0, 0, 1, 5'h0c);
    #1;
    checks++; if (bus.dec_ready !== 1'b0) begin errors++; $display("FAIL drain_block got %0b want 0", bus.dec_ready); end
    cycle();
    set_wb(1, 5'h0a);
    #1;
    checks++; if (fpscr_wr_ack !== 1'b0) begin errors++; $display("FAIL drain_early_ack1 got %0b want 0", fpscr_wr_ack); end
    cycle();
    set_wb(1, 5'h0b);
    #1;
    checks++; if (fpscr_wr_ack !== 1'b0) begin errors++; $display("FAIL drain_early_ack2 got %0b want 0", fpscr_wr_ack); end
    cycle();
    set_wb(0, 0);
    #1;
    checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL drain_empty got %0d want 0", inflight); end
    checks++; if (fpscr_wr_ack !== 1'b0) begin errors++; $display("FAIL drain_ack_zero_cycle got %0b want 0", fpscr_wr_ack); end
    checks++; if (bus.dec_ready !== 1'b0) begin errors++; $display("FAIL drain_still_block got %0b want 0", bus.dec_ready); end
    cycle();
    checks++; if (fpscr_wr_ack !== 1'b1) begin errors++; $display("FAIL drain_ack got %0b want 1", fpscr_wr_ack); end
    checks++; if (bus.dec_ready !== 1'b0) begin errors++; $display("FAIL drain_ack_block got %0b want 0", bus.dec_ready); end
    fpscr_wr_req = 1'b0;
    cycle();
    checks++; if (fpscr_wr_ack !== 1'b0) begin errors++; $display("FAIL drain_ack_pulse got %0b want 0", fpscr_wr_ack); end
    checks++; if (bus.dec_ready !== 1'b1) begin errors++; $display("FAIL drain_resume got %0b want 1", bus.dec_ready); end
    cycle();
    set_op(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (inflight !== 3'd1) begin errors++; $display("FAIL drain_resume_cnt got %0d want 1", inflight); end
    set_wb(1, 5'h0c);
    cycle();
    set_wb(0, 0);
  endtask

  task automatic test_err();
    set_wb(1, 5'h09);
    cycle();
    set_wb(0, 0);
    checks++; if (err_wb !== 1'b1) begin errors++; $display("FAIL err_set got %0b want 1", err_wb); end
    checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL err_inflight got %0d want 0", inflight); end
    repeat (3) cycle();
    checks++; if (err_wb !== 1'b1) begin errors++; $display("FAIL err_sticky got %0b want 1", err_wb); end
  endtask

  task automatic test_reset_midop();
    set_op(1, 0, 0, 0, 0, 0, 0, 1, 5'h0d); cycle();
    set_op(1, 0, 0, 0, 0, 0, 0, 1, 5'h0e); cycle();
    set_op(1, 0, 0, 0, 0, 0, 0, 1, 5'h0f); cycle();
    set_op(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (inflight !== 3'd3) begin errors++; $display("FAIL mid_pre got %0d want 3", inflight); end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL mid_inflight got %0d want 0", inflight); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL mid_idle got %0b want 1", idle); end
    checks++; if (err_wb !== 1'b0) begin errors++; $display("FAIL mid_err got %0b want 0", err_wb); end
    checks++; if (dut.u_sb.pending !== 32'h0) begin errors++; $display("FAIL mid_pending got %h want 0", dut.u_sb.pending); end
    set_op(1, 1, 5'h0d, 0, 0, 0, 0, 1, 5'h10);
    #1;
    checks++; if (bus.dec_ready !== 1'b1) begin errors++; $display("FAIL mid_dep_issue got %0b want 1", bus.dec_ready); end
    cycle();
    set_op(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (dut.u_sb.pending[16] !== 1'b1) begin errors++; $display("FAIL mid_pend16 got %0b want 1", dut.u_sb.pending[16]); end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_full();
    test_no_dst();
    test_drain();
    test_err();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
